stage2_root: RTL and testbench
==============================

Name: stage2_root

Overview:
- Second stage of the per-servo inverse-kinematics pipeline; sits directly downstream of stage 1, which produces L, M and N.
- Computes D = floor(sqrt(M^2 + N^2)) with a multi-cycle digit-by-digit integer square root.
- Forwards L, M and N registered alongside D, and flags whether the leg pose is reachable (L <= D).
- Stage 3 consumes D, L, M and N for the asin/atan angle evaluation.

Parameters:
- RW, 15, root width and number of square-root iterations (sqrt of a sum below 2^30 fits in 15 bits).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- validIn  input  1  single-cycle pulse from stage 1; L/M/N are valid while it is high.
- L  input  16  unsigned, from stage 1.
- M  input  14  unsigned, from stage 1.
- N  input  15  signed two's complement, from stage 1.
- D  output  RW  floor(sqrt(M^2+N^2)), unsigned.
- L_out  output  16  captured L.
- M_out  output  14  captured M.
- N_out  output  15  captured N, signed.
- reachable  output  1  1 when L_out <= D.
- busy  output  1  high while a transaction is in flight (states SQUARE/ROOT).
- validOut  output  1  one-cycle pulse; D, L_out, M_out, N_out and reachable are valid while it is high.

Behaviour:
- Reset (async, any time): state=IDLE; D, L_out, M_out, N_out, reachable, busy, validOut all 0; internal remainder, radicand and iteration counter cleared. An in-flight transaction is abandoned, with no validOut.
- States: IDLE -> SQUARE -> ROOT -> IDLE.
- IDLE: on an edge with validIn=1, latch L/M/N into L_out/M_out/N_out; go to SQUARE; busy=1. validIn=0 stays in IDLE.
- SQUARE (1 cycle):
  - S = M_out*M_out + N_out*N_out, as a 30-bit unsigned value.
  - N squared as signed then treated as non-negative; no overflow is possible (max S = 536838145).
  - Init root=0, remainder=0, iter=RW-1; go to ROOT.
- ROOT (RW cycles): standard non-restoring/restoring digit-by-digit sqrt, consuming 2 bits of S per cycle MSB-first, producing 1 root bit per cycle. iter decrements each cycle.
- ROOT exit: on the edge where iter==0:
  - write final root to D;
  - reachable = ({1'b0,L_out} <= {2'b0,D_final}), compared as unsigned 17-bit;
  - validOut=1, busy=0, state=IDLE.
- validOut timing: high for exactly one cycle, cleared on the next edge.
- Latency: capture edge C0, validOut rises at edge C0+1+RW (C16 for RW=15). Min initiation interval RW+2 cycles.
- D, L_out, M_out, N_out and reachable hold their values after validOut until the next completion (or reset).
- L_out/M_out/N_out change at the capture edge. The consumer samples only on validOut.
- validIn while busy=1 (SQUARE/ROOT, including the completion edge): ignored, no queuing. Stage 1 output is single-shot, so dropping is the decided behaviour.
- validIn on the first IDLE cycle after completion: accepted normally.
- Exactness: D is exact floor for all inputs, including 0 and perfect squares. No rounding.

Test Plan:
- M=3, N=4, L=5, validIn pulse -> validOut after 16 cycles; D=5, reachable=1, L_out=5, M_out=3, N_out=4.
- M=3, N=-4, L=6 -> D=5, reachable=0, N_out=-4.
- M=10, N=-10, L=14 -> S=200, D=14, reachable=1. Then M=0, N=0, L=0 -> D=0, reachable=1.
- M=16383, N=-16384, L=65535 -> S=536838145, D=23169, reachable=0.
- Pulse validIn again at cycles 3 and 16 after the first capture -> both ignored. Exactly one validOut; a pulse at cycle 17 is accepted and completes 16 cycles later.
- Assert reset for 1 cycle at cycle 7 of a transaction -> all outputs 0 immediately (async), no validOut; next transaction (M=3, N=4) completes correctly with D=5.

Source files
------------

// File: rtl/stage2_root_if.sv
// stage2_root_if: bundles the stage-1 -> stage-2 -> stage-3 signals for the
// inverse-kinematics root stage.
//   validIn, L, M, N          : request side, driven by stage 1 (master)
//   D, L_out, M_out, N_out,
//   reachable, busy, validOut : result side, driven by stage 2 (slave)
interface stage2_root_if #(
  parameter int RW = 15
);
  logic                validIn;
  logic [15:0]         L;
  logic [13:0]         M;
  logic signed [14:0]  N;
  logic [RW-1:0]       D;
  logic [15:0]         L_out;
  logic [13:0]         M_out;
  logic signed [14:0]  N_out;
  logic                reachable;
  logic                busy;
  logic                validOut;

  modport master (
    output validIn, L, M, N,
    input  D, L_out, M_out, N_out, reachable, busy, validOut
  );

  modport slave (
    input  validIn, L, M, N,
    output D, L_out, M_out, N_out, reachable, busy, validOut
  );
endinterface

// File: rtl/stage2_root.sv
// stage2_root: second stage of the per-servo IK pipeline.
// Captures L/M/N, computes D = floor(sqrt(M^2 + N^2)) with a digit-by-digit
// integer square root (one root bit per cycle), and reports whether the
// pose is reachable (L <= D).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : stage2_root_if.slave (validIn/L/M/N in; D/L_out/M_out/N_out/
//           reachable/busy/validOut out)
// Latency: capture edge C0 -> validOut at C0+1+RW. Requests arriving while
// busy (including the completion edge) are dropped.
module stage2_root #(
  parameter int RW = 15
) (
  input  logic          clock,
  input  logic          reset,
  stage2_root_if.slave  bus
);

  localparam int SW    = 2 * RW;          // radicand width
  localparam int REM_W = RW + 1;          // remainder never exceeds 2*root
  localparam int IW    = $clog2(RW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    ROOT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        l_q, l_d;
  logic [13:0]        m_q, m_d;
  logic signed [14:0] n_q, n_d;
  logic [SW-1:0]      rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [RW-1:0]      root_q, root_d;
  logic [IW-1:0]      iter_q, iter_d;
  logic [RW-1:0]      d_q, d_d;
  logic               reachable_q, reachable_d;
  logic               busy_q, busy_d;
  logic               valid_out_q, valid_out_d;

  // Squares; N is squared as signed so the product is always non-negative.
  logic [27:0]        m_sq;
  logic signed [29:0] n_sq;
  logic [SW-1:0]      square_sum;

  assign m_sq       = m_q * m_q;
  assign n_sq       = n_q * n_q;
  assign square_sum = SW'(m_sq) + SW'($unsigned(n_sq));

  // One restoring sqrt step: bring down the next 2 radicand bits and try
  // subtracting (4*root + 1); success yields a 1 root bit.
  logic [REM_W+1:0] rem_shift;
  logic [REM_W+1:0] trial;
  logic             take;
  logic [REM_W+1:0] rem_step;
  logic [RW-1:0]    root_step;

  assign rem_shift = {rem_q, rad_q[SW-1 -: 2]};
  assign trial     = {1'b0, root_q, 2'b01};
  assign take      = (rem_shift >= trial);
  assign rem_step  = take ? (rem_shift - trial) : rem_shift;
  assign root_step = {root_q[RW-2:0], take};

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    m_d         = m_q;
    n_d         = n_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    iter_d      = iter_q;
    d_d         = d_q;
    reachable_d = reachable_q;
    busy_d      = busy_q;
    valid_out_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.validIn) begin
          l_d     = bus.L;
          m_d     = bus.M;
          n_d     = bus.N;
          busy_d  = 1'b1;
          state_d = SQUARE;
        end
      end

      SQUARE: begin
        rad_d   = square_sum;
        rem_d   = '0;
        root_d  = '0;
        iter_d  = IW'(RW - 1);
        state_d = ROOT;
      end

      ROOT: begin
        rad_d  = rad_q << 2;
        rem_d  = REM_W'(rem_step);
        root_d = root_step;
        if (iter_q == '0) begin
          d_d         = root_step;
          reachable_d = ({1'b0, l_q} <= {2'b0, root_step});
          valid_out_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          iter_d = iter_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      l_q         <= '0;
      m_q         <= '0;
      n_q         <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      iter_q      <= '0;
      d_q         <= '0;
      reachable_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      m_q         <= m_d;
      n_q         <= n_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      iter_q      <= iter_d;
      d_q         <= d_d;
      reachable_q <= reachable_d;
      busy_q      <= busy_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.D         = d_q;
  assign bus.L_out     = l_q;
  assign bus.M_out     = m_q;
  assign bus.N_out     = n_q;
  assign bus.reachable = reachable_q;
  assign bus.busy      = busy_q;
  assign bus.validOut  = valid_out_q;

endmodule

// File: tb/tb_stage2_root.sv
// tb_stage2_root: directed-vector bench for stage2_root with hand-computed
// expected values; one line printed per transaction.
module tb_stage2_root;

  logic clk;
  logic rst;

  stage2_root_if #(.RW(15)) bus ();

  stage2_root #(.RW(15)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total;
  int checks_passed;
  int vo_count;

  initial vo_count = 0;
  always @(negedge clk) begin
    if (bus.validOut === 1'b1) vo_count++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp_v);
    checks_total++;
    if (obs === exp_v) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] l, input logic [13:0] m,
                        input logic [14:0] n);
    bus.L       = l;
    bus.M       = m;
    bus.N       = n;
    bus.validIn = 1'b1;
    step();
    bus.validIn = 1'b0;
  endtask

  // Waits (bounded) for validOut after a capture and checks the result.
  task automatic finish_txn(input string name, input logic [15:0] l,
                            input logic [13:0] m, input logic [14:0] n,
                            input logic [14:0] d_exp, input logic r_exp);
    int k;
    check_val({name, ":busy_after_capture"}, 32'(bus.busy), 32'd1);
    k = 0;
    while (bus.validOut !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check_val({name, ":latency"}, 32'(k), 32'd16);
    check_val({name, ":D"}, 32'(bus.D), 32'(d_exp));
    check_val({name, ":reachable"}, 32'(bus.reachable), 32'(r_exp));
    check_val({name, ":L_out"}, 32'(bus.L_out), 32'(l));
    check_val({name, ":M_out"}, 32'(bus.M_out), 32'(m));
    check_val({name, ":N_out"}, {17'b0, bus.N_out}, {17'b0, n});
    check_val({name, ":busy_done"}, 32'(bus.busy), 32'd0);
    $display("txn %s: L=%0d M=%0d N=%0d -> D=%0d reachable=%0d latency=%0d",
             name, bus.L_out, bus.M_out, bus.N_out, bus.D, bus.reachable, k);
    step();
    check_val({name, ":validOut_pulse"}, 32'(bus.validOut), 32'd0);
    check_val({name, ":D_hold"}, 32'(bus.D), 32'(d_exp));
  endtask

  task automatic run_txn(input string name, input logic [15:0] l,
                         input logic [13:0] m, input logic [14:0] n,
                         input logic [14:0] d_exp, input logic r_exp);
    launch(l, m, n);
    finish_txn(name, l, m, n, d_exp, r_exp);
  endtask

  task automatic check_zero(input string name);
    check_val({name, ":D"}, 32'(bus.D), 32'd0);
    check_val({name, ":L_out"}, 32'(bus.L_out), 32'd0);
    check_val({name, ":M_out"}, 32'(bus.M_out), 32'd0);
    check_val({name, ":N_out"}, {17'b0, bus.N_out}, 32'd0);
    check_val({name, ":reachable"}, 32'(bus.reachable), 32'd0);
    check_val({name, ":busy"}, 32'(bus.busy), 32'd0);
    check_val({name, ":validOut"}, 32'(bus.validOut), 32'd0);
  endtask

  initial begin
    int vo_before;
    checks_total  = 0;
    checks_passed = 0;
    rst         = 1'b1;
    bus.validIn = 1'b0;
    bus.L       = '0;
    bus.M       = '0;
    bus.N       = '0;
    #2;
    check_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();

    // 3-4-5 triangle, reachable exactly at the boundary L == D.
    run_txn("m3_n4_l5", 16'd5, 14'd3, 15'd4, 15'd5, 1'b1);
    // N = -4 (15'h7FFC); L one past D.
    run_txn("m3_nneg4_l6", 16'd6, 14'd3, 15'h7FFC, 15'd5, 1'b0);
    // S = 200, floor(sqrt) = 14.
    run_txn("m10_nneg10_l14", 16'd14, 14'd10, 15'h7FF6, 15'd14, 1'b1);
    run_txn("zero", 16'd0, 14'd0, 15'd0, 15'd0, 1'b1);
    // M max, N = -16384 (15'h4000): S = 536838145, D = 23169.
    run_txn("max", 16'd65535, 14'd16383, 15'h4000, 15'd23169, 1'b0);

    // Requests while busy are dropped; first IDLE cycle accepts.
    vo_before = vo_count;
    launch(16'd5, 14'd3, 15'd4);            // capture at C0
    step();
    step();
    bus.L = 16'd1; bus.M = 14'd1; bus.N = 15'd0;
    bus.validIn = 1'b1;
    step();                                 // pulse at C3
    bus.validIn = 1'b0;
    for (int i = 0; i < 12; i++) step();
    bus.L = 16'd2; bus.M = 14'd2; bus.N = 15'd2;
    bus.validIn = 1'b1;
    step();                                 // pulse at C16 (completion edge)
    check_val("drop:validOut_c16", 32'(bus.validOut), 32'd1);
    check_val("drop:D", 32'(bus.D), 32'd5);
    check_val("drop:L_out", 32'(bus.L_out), 32'd5);
    $display("txn drop_busy: L=%0d M=%0d N=%0d -> D=%0d reachable=%0d",
             bus.L_out, bus.M_out, bus.N_out, bus.D, bus.reachable);
    bus.L = 16'd14; bus.M = 14'd10; bus.N = 15'h7FF6;
    step();                                 // pulse at C17 is accepted
    bus.validIn = 1'b0;
    check_val("drop:one_validOut", 32'(vo_count - vo_before), 32'd1);
    finish_txn("accept_c17", 16'd14, 14'd10, 15'h7FF6, 15'd14, 1'b1);

    // Async reset mid-transaction abandons it.
    vo_before = vo_count;
    launch(16'd7, 14'd3, 15'd4);
    for (int i = 0; i < 6; i++) step();
    #3;
    rst = 1'b1;
    #1;
    check_zero("midreset");
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_val("midreset:no_validOut", 32'(vo_count - vo_before), 32'd0);
    $display("txn midreset: abandoned, validOut count delta=%0d",
             vo_count - vo_before);
    run_txn("after_reset", 16'd5, 14'd3, 15'd4, 15'd5, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
